// File: rtl/config_pkg.sv
// Shared core configuration and the divider state type used by the MDU.
// Also holds the 32-bit extension helpers used by W-type operations.
package config_pkg;

  localparam int XLEN        = 64;
  localparam bit M_SUPPORTED = 1'b1;
  localparam bit IDIV_ON_FPU = 1'b0;

  // Iteration counter must reach XLEN-1.
  localparam int DIV_CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    r = x;
    for (int i = 32; i < XLEN; i++) r[i] = x[31];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    r = x;
    for (int i = 32; i < XLEN; i++) r[i] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/divradix2_iter_divstep.sv
// One restoring division step: shift {R,Q} left, subtract |B| when it fits.
// Purely combinational; R is always below |B| on entry.
module divstep #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_r,
  input  logic [XLEN-1:0] i_q,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_r,
  output logic [XLEN-1:0] o_q
);

  logic [XLEN:0] w_r_sh;
  logic [XLEN:0] w_trial;

  // R < |B| keeps the shifted remainder below 2|B|, so XLEN+1 bits hold the signed trial.
  assign w_r_sh  = {i_r, i_q[XLEN-1]};
  assign w_trial = w_r_sh - {1'b0, i_b};

  assign o_r = w_trial[XLEN] ? w_r_sh[XLEN-1:0] : w_trial[XLEN-1:0];
  assign o_q = {i_q[XLEN-2:0], ~w_trial[XLEN]};

endmodule

// File: rtl/divradix2_iter.sv
// Iterative radix-2 restoring divider for div/divu/rem/remu and the RV64 W forms.
// Stalls Execute while iterating and holds QuotM/RemM for the Memory stage.
module divradix2_iter
  import config_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            StallM,
  input  logic            FlushE,
  input  logic            IntDivE,
  input  logic            DivSignedE,
  input  logic            W64E,
  input  logic [XLEN-1:0] ForwardedSrcAE,
  input  logic [XLEN-1:0] ForwardedSrcBE,
  output logic            DivBusyE,
  output logic [XLEN-1:0] QuotM,
  output logic [XLEN-1:0] RemM
);

  div_state_t r_state, w_state_nxt;

  logic [DIV_CNT_W-1:0] r_count;
  logic [XLEN-1:0]      r_r, r_q, r_b;
  logic                 r_neg_q, r_neg_r, r_w64;
  logic [XLEN-1:0]      r_quot, r_rem;

  logic                 w_start, w_w64, w_sign_a, w_sign_b, w_b_zero, w_last_step;
  logic [XLEN-1:0]      w_a_ext, w_b_ext, w_abs_a, w_abs_b, w_q_init;
  logic [XLEN-1:0]      w_r_nxt, w_q_nxt, w_q_fix, w_r_fix;
  logic [DIV_CNT_W-1:0] w_last_cnt;

  // Operand preparation in Execute
  assign w_w64   = (XLEN == 64) && W64E;
  assign w_a_ext = !w_w64 ? ForwardedSrcAE :
                   (DivSignedE ? sext32(ForwardedSrcAE) : zext32(ForwardedSrcAE));
  assign w_b_ext = !w_w64 ? ForwardedSrcBE :
                   (DivSignedE ? sext32(ForwardedSrcBE) : zext32(ForwardedSrcBE));

  assign w_sign_a = DivSignedE & w_a_ext[XLEN-1];
  assign w_sign_b = DivSignedE & w_b_ext[XLEN-1];
  assign w_abs_a  = w_sign_a ? -w_a_ext : w_a_ext;
  assign w_abs_b  = w_sign_b ? -w_b_ext : w_b_ext;
  assign w_b_zero = (w_b_ext == '0);

  // W-type: park the 32-bit dividend at the top so 32 shifts consume exactly it.
  assign w_q_init = w_w64 ? (w_abs_a << 32) : w_abs_a;

  assign w_start  = (r_state == IDLE) & IntDivE & ~FlushE;
  assign DivBusyE = ~reset & (w_start | (r_state == BUSY));

  assign w_last_cnt  = r_w64 ? DIV_CNT_W'(31) : DIV_CNT_W'(XLEN - 1);
  assign w_last_step = (r_count == w_last_cnt);

  divstep #(.XLEN(XLEN)) u_divstep (
    .i_r (r_r),
    .i_q (r_q),
    .i_b (r_b),
    .o_r (w_r_nxt),
    .o_q (w_q_nxt)
  );

  // Sign fixup applied to the final step's output; overflow needs no extra path.
  always_comb begin
    w_q_fix = r_neg_q ? -w_q_nxt : w_q_nxt;
    w_r_fix = r_neg_r ? -w_r_nxt : w_r_nxt;
    if (r_w64) begin
      w_q_fix = sext32(w_q_fix);
      w_r_fix = sext32(w_r_fix);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: default assigned first so every path drives w_state_nxt and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = w_b_zero ? DONE : BUSY;
      BUSY:    if (FlushE) w_state_nxt = IDLE;
               else if (w_last_step) w_state_nxt = DONE;
      DONE:    if (!StallM) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_r     <= '0;
      r_q     <= '0;
      r_b     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_w64   <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
    end else if (w_start) begin
      r_count <= '0;
      r_r     <= '0;
      r_q     <= w_q_init;
      r_b     <= w_abs_b;
      r_neg_q <= w_sign_a ^ w_sign_b;
      r_neg_r <= w_sign_a;
      r_w64   <= w_w64;
      if (w_b_zero) begin
        r_quot <= '1;
        r_rem  <= w_w64 ? sext32(w_a_ext) : w_a_ext;
      end
    end else if (r_state == BUSY) begin
      r_count <= r_count + 1'b1;
      r_r     <= w_r_nxt;
      r_q     <= w_q_nxt;
      if (!FlushE && w_last_step) begin
        r_quot <= w_q_fix;
        r_rem  <= w_r_fix;
      end
    end
  end

  assign QuotM = r_quot;
  assign RemM  = r_rem;

endmodule
